// File: rtl/spi_slave.sv
// spi_slave: SPI slave supporting all four modes, with a one-entry TX buffer and a byte-wide receive path
module spi_slave (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       ss_n_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_load_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o
);
    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e     state_q;
    logic [2:0] sclk_q, mosi_q, ss_q, bit_q;
    logic [1:0] warm_q;
    logic [6:0] rx_sr_q;
    logic [7:0] tx_sr_q, tx_buf_q, rx_data_q;
    logic       cpol_q, cpha_q, first_q, reload_q, tx_full_q, rx_valid_q;
    logic       warm, active, sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic       lead, trail, sample, shift, hold_first, start, reload, buf_load;
    logic [7:0] tx_fill;

    // Bits [1:0] form the synchronizer and bit [2] is the edge-detect delay.
    // Edges are masked until the whole chain holds real pin samples, so the
    // reset contents can never look like an SCLK or ss_n transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= 3'b000;
            mosi_q <= 3'b000;
            ss_q   <= 3'b111;
            warm_q <= 2'd0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            mosi_q <= {mosi_q[1:0], mosi_i};
            ss_q   <= {ss_q[1:0], ss_n_i};
            warm_q <= warm_q + {1'b0, ~&warm_q};
        end
    end

    assign warm       = &warm_q;
    assign active     = state_q == ACTIVE;
    assign sclk_rise  = warm & sclk_q[1] & ~sclk_q[2];
    assign sclk_fall  = warm & ~sclk_q[1] & sclk_q[2];
    assign ss_fall    = warm & ~ss_q[1] & ss_q[2];
    assign ss_rise    = warm & ss_q[1] & ~ss_q[2];
    assign lead       = cpol_q ? sclk_fall : sclk_rise;
    assign trail      = cpol_q ? sclk_rise : sclk_fall;
    assign sample     = cpha_q ? trail : lead;
    assign shift      = cpha_q ? lead : trail;
    assign hold_first = cpha_q & first_q;
    assign start      = ~active & ss_fall;
    assign reload     = active & ~ss_rise & shift & ~hold_first & reload_q;
    assign buf_load   = start | reload;
    assign tx_fill    = tx_full_q ? tx_buf_q : 8'h00;

    // Transfer FSM: select handling, receive shifting and transmit shifting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            bit_q      <= 3'd0;
            first_q    <= 1'b0;
            reload_q   <= 1'b0;
            rx_sr_q    <= 7'd0;
            tx_sr_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!active) begin
                if (ss_fall) begin
                    state_q  <= ACTIVE;
                    cpol_q   <= cpol_i;
                    cpha_q   <= cpha_i;
                    bit_q    <= 3'd0;
                    first_q  <= 1'b1;
                    reload_q <= 1'b0;
                    tx_sr_q  <= tx_fill;
                end
            end else if (ss_rise) begin
                state_q  <= IDLE;
                bit_q    <= 3'd0;
                first_q  <= 1'b0;
                reload_q <= 1'b0;
            end else if (sample) begin
                rx_sr_q <= {rx_sr_q[5:0], mosi_q[2]};
                bit_q   <= bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    rx_data_q  <= {rx_sr_q, mosi_q[2]};
                    rx_valid_q <= 1'b1;
                    reload_q   <= 1'b1;
                end
            end else if (shift) begin
                if (hold_first)
                    first_q <= 1'b0;
                else if (reload_q) begin
                    tx_sr_q  <= tx_fill;
                    reload_q <= 1'b0;
                end else
                    tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end
        end
    end

    // One-entry TX buffer; a host write in the same cycle as a drain refills it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_buf_q  <= 8'h00;
            tx_full_q <= 1'b0;
        end else if (tx_load_i && (!tx_full_q || buf_load)) begin
            tx_buf_q  <= tx_data_i;
            tx_full_q <= 1'b1;
        end else if (buf_load)
            tx_full_q <= 1'b0;
    end

    assign miso_o     = active & tx_sr_q[7];
    assign miso_oe_o  = active;
    assign busy_o     = active;
    assign tx_ready_o = ~tx_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: behavioural SPI master plus byte-level reference model for spi_slave
module tb_spi_slave;
    localparam int HALF = 8;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    logic       miso, miso_oe, tx_load = 1'b0, tx_ready, rx_valid, busy;
    logic [7:0] tx_data = 8'h00, rx_data;

    int         checks = 0, failures = 0, cyc = 0;
    logic [7:0] mo_a[4], tx_a[4], mi_a[4];
    bit         ld_a[4];
    logic [7:0] got_rx[$];
    int         got_cyc[$], exp_cyc[$];
    int         done_bits, stop_at;
    bit         stop_x, simul_x;
    logic [7:0] last_rx = 8'h00;

    spi_slave dut (
        .clk_i(clk), .rst_ni(rst_n), .cpol_i(cpol), .cpha_i(cpha),
        .sclk_i(sclk), .mosi_i(mosi), .ss_n_i(ss_n),
        .miso_o(miso), .miso_oe_o(miso_oe),
        .tx_data_i(tx_data), .tx_load_i(tx_load), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            got_rx.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_load(input logic [7:0] d);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_wait", int'(tx_ready), 1);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic mark_sample(input int b);
        if (simul_x && done_bits + 1 == stop_at) begin
            ss_n   = 1'b1;
            stop_x = 1'b1;
        end else if (b == 0)
            exp_cyc.push_back(cyc + 3);
    endtask

    task automatic xfer(input bit pol, input bit pha, input int n);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        ss_n = 1'b1;
        clks(4);
        got_rx.delete();
        got_cyc.delete();
        exp_cyc.delete();
        done_bits = 0;
        stop_x    = 1'b0;
        if (ld_a[0]) host_load(tx_a[0]);
        mosi = pha ? 1'b0 : mo_a[0][7];
        ss_n = 1'b0;
        clks(HALF);
        for (int k = 0; k < n && !stop_x; k++) begin
            mi_a[k] = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                if (!pha) mi_a[k][b] = miso;
                else mosi = mo_a[k][b];
                sclk = ~pol;
                if (!pha) mark_sample(b);
                clks(HALF);
                if (stop_x) break;
                if (pha) mi_a[k][b] = miso;
                sclk = pol;
                if (pha) mark_sample(b);
                if (!pha) mosi = (b > 0) ? mo_a[k][b-1] : ((k + 1 < n) ? mo_a[k+1][7] : 1'b0);
                clks(HALF);
                if (stop_x) break;
                done_bits++;
                if (done_bits == stop_at) begin
                    stop_x = 1'b1;
                    break;
                end
                if (b == 7 && k + 1 < n && ld_a[k+1]) host_load(tx_a[k+1]);
            end
        end
        ss_n = 1'b1;
        clks(2);
        sclk = pol;
        clks(HALF);
    endtask

    task automatic verify(input int n);
        int nb;
        nb = stop_x ? done_bits / 8 : n;
        check("rx_count", got_rx.size(), nb);
        for (int i = 0; i < nb; i++) begin
            if (i < got_rx.size()) begin
                check("rx_byte", int'(got_rx[i]), int'(mo_a[i]));
                check("rx_latency", got_cyc[i], exp_cyc[i]);
            end
            check("master_rx", int'(mi_a[i]), ld_a[i] ? int'(tx_a[i]) : 0);
        end
        if (nb > 0) last_rx = mo_a[nb-1];
        check("rx_data_hold", int'(rx_data), int'(last_rx));
        check("busy_end", int'(busy), 0);
        check("miso_oe_end", int'(miso_oe), 0);
        check("miso_end", int'(miso), 0);
        check("tx_ready_end", int'(tx_ready), 1);
    endtask

    task automatic run(input bit pol, input bit pha, input int n, input int stop, input bit simul);
        stop_at = stop;
        simul_x = simul;
        xfer(pol, pha, n);
        verify(n);
    endtask

    task automatic set1(input logic [7:0] tx, input logic [7:0] mo);
        tx_a[0] = tx;
        mo_a[0] = mo;
        ld_a[0] = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, int'(rx_data), 0);
        check({tag, "_rx_valid"}, int'(rx_valid), 0);
        check({tag, "_tx_ready"}, int'(tx_ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_miso"}, int'(miso), 0);
        check({tag, "_miso_oe"}, int'(miso_oe), 0);
    endtask

    initial begin
        @(negedge clk);
        clks(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        clks(5);

        set1(8'hA5, 8'h3C);
        run(0, 0, 1, -1, 0);
        set1(8'h81, 8'h7E);
        run(1, 1, 1, -1, 0);
        run(0, 1, 1, -1, 0);
        run(1, 0, 1, -1, 0);

        set1(8'h12, 8'hF0);
        tx_a[1] = 8'h34; mo_a[1] = 8'h0F; ld_a[1] = 1'b1;
        run(0, 0, 2, -1, 0);
        run(1, 1, 2, -1, 0);

        set1(8'h12, 8'h5D);
        mo_a[1] = 8'hB6; ld_a[1] = 1'b0;
        run(0, 1, 2, -1, 0);

        set1(8'h99, 8'hE7);
        run(0, 0, 1, 5, 0);
        set1(8'h44, 8'hC3);
        run(0, 0, 1, -1, 0);

        set1(8'h27, 8'h6B);
        run(0, 1, 1, 8, 1);
        set1(8'h27, 8'h6B);
        run(1, 0, 1, 8, 1);
        set1(8'h55, 8'hC3);
        run(1, 0, 1, -1, 0);

        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1;
        clks(4);
        host_load(8'h5A);
        mosi = 1'b1;
        ss_n = 1'b0;
        clks(HALF);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1; clks(HALF);
            sclk = 1'b0; clks(HALF);
        end
        host_load(8'h66);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_tx_ready", int'(tx_ready), 0);
        got_rx.delete();
        rst_n = 1'b0;
        clks(2);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        clks(4);
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1; clks(HALF);
            sclk = 1'b0; clks(HALF);
        end
        check("post_reset_no_rx", got_rx.size(), 0);
        check("post_reset_busy", int'(busy), 0);
        ss_n = 1'b1;
        clks(HALF);
        last_rx = 8'h00;
        set1(8'h3A, 8'hC3);
        run(0, 0, 1, -1, 0);

        for (int t = 0; t < 16; t++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                tx_a[k] = 8'($urandom);
                mo_a[k] = 8'($urandom);
                ld_a[k] = ($urandom % 4) != 0;
            end
            run(1'($urandom), 1'($urandom), n, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
